serial_add_seq: RTL and testbench
=================================

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit slices per operand (operand width W = 4*NIBBLES, NIBBLES >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand set offered.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand set.
REQ-006 SHALL have port a  input  W  operand A, sampled on accept.
REQ-007 SHALL have port b  input  W  operand B, sampled on accept.
REQ-008 SHALL have port cin  input  1  carry-in to nibble 0, sampled on accept.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port sum  output  W  result {sum} of a+b+cin modulo 2^W.
REQ-012 SHALL have port cout  output  1  carry out of bit W-1.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-015 Accept = in_valid && in_ready at a rising edge: latch a, b, cin into operand registers, clear nibble index to 0, go to RUN.
REQ-016 Each RUN cycle SHALL add nibble [idx] of A and B plus the carry register through one 4-bit adder, write the 4-bit result into sum slice [idx], store the adder carry-out into the carry register, increment idx.
REQ-017 After the cycle computing idx = NIBBLES-1, SHALL go to DONE with cout = final carry; out_valid rises exactly NIBBLES cycles after the accept edge.
REQ-018 In DONE, sum and cout SHALL hold stable until out_valid && out_ready; on that edge go to IDLE (in_ready high next cycle).
REQ-019 No overlap: in_valid while in RUN or DONE SHALL be ignored and operands not sampled.
REQ-020 Minimum throughput: one result per NIBBLES+2 cycles with out_ready held high.
REQ-021 sum slices not yet computed in RUN are don't-care; only DONE values are defined.
REQ-022 Operand changes on a/b/cin after accept SHALL not affect the result.

Reset
REQ-023 rst_n low at a rising edge SHALL force IDLE, idx = 0, carry register = 0, sum = 0, cout = 0, out_valid = 0; in_ready = 1 from the first cycle after rst_n returns high.
REQ-024 Reset in RUN or DONE SHALL abandon the operation with no result presented.

Configuration
REQ-025 Macro SERIAL_ADD_OVF_EN defined: SHALL add output port ovf (1 bit), signed two's-complement overflow of the W-bit add, = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]), valid in DONE, reset to 0.
REQ-026 Macro undefined: no ovf port, no ovf logic; all other behaviour identical.

Structure
REQ-027 Shared package serial_add_pkg SHALL hold NIBBLE_W = 4 and the FSM state encoding (IDLE, RUN, DONE).
REQ-028 SHALL instantiate one combinational sub-module nibble_add4 (4-bit a, b, cin -> 4-bit sum, cout); all arithmetic goes through it.

Verification
REQ-029 NIBBLES=4, a=16'hFFFF, b=16'h0001, cin=0 -> out_valid exactly 4 cycles after accept, sum=16'h0000, cout=1.
REQ-030 a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0; in_ready low from accept until the edge after out_valid&&out_ready.
REQ-031 out_ready held low 3 cycles in DONE -> sum/cout stable, in_ready 0, in_valid pulses with a=16'hAAAA ignored; next result still from original operands.
REQ-032 rst_n low for 1 cycle 2 cycles into RUN -> out_valid 0, sum 0, in_ready 1 after release; new accept a=16'h0F0F, b=16'h00F1, cin=0 -> sum=16'h1000, cout=0.
REQ-033 SERIAL_ADD_OVF_EN defined: a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1; a=16'h8000, b=16'h8000 -> sum=16'h0000, cout=1, ovf=1.
REQ-034 Back-to-back with out_ready=1, in_valid=1: accepts spaced exactly 6 cycles (NIBBLES+2).

Source files
------------

// File: rtl/serial_add_pkg.sv
// ----------------------------------------------------------------------------
// serial_add_pkg
// Shared constants for the nibble-serial adder:
//   NIBBLE_W         width of one adder slice
//   IDLE / RUN / DONE  sequencer state encoding
// ----------------------------------------------------------------------------
package serial_add_pkg;

   localparam int NIBBLE_W = 4;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/nibble_add4.sv
// ----------------------------------------------------------------------------
// nibble_add4
// Combinational 4-bit slice adder; the only arithmetic in the serial adder.
// Ports:
//   i_a, i_b  [3:0]  slice operands
//   i_cin            carry in
//   o_sum     [3:0]  slice sum
//   o_cout           carry out of bit 3
// ----------------------------------------------------------------------------
module nibble_add4
   import serial_add_pkg::*;
(
   input  logic [NIBBLE_W-1:0] i_a,
   input  logic [NIBBLE_W-1:0] i_b,
   input  logic                i_cin,
   output logic [NIBBLE_W-1:0] o_sum,
   output logic                o_cout
);

   // Zero-extend each operand so the carry lands in the top bit.
   assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{NIBBLE_W{1'b0}}, i_cin};

endmodule

// File: rtl/serial_add_seq.sv
// ----------------------------------------------------------------------------
// serial_add_seq
// Nibble-serial W-bit adder (W = 4*NIBBLES). One operand set is accepted in
// IDLE, one nibble is added per RUN cycle through a single nibble_add4, and
// the result is held in DONE until the consumer takes it.
// Optional build macro SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  operand handshake (a, b, cin sampled on accept)
//   out_valid/out_ready  result handshake (sum, cout, [ovf])
// ----------------------------------------------------------------------------
module serial_add_seq
   import serial_add_pkg::*;
#(
   parameter int NIBBLES = 4
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0] a,
   input  logic [NIBBLE_W*NIBBLES-1:0] b,
   input  logic                        cin,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NIBBLE_W*NIBBLES-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
   output logic                        ovf,
`endif
   output logic                        cout
);

   localparam int W  = NIBBLE_W * NIBBLES;
   localparam int IW = $clog2(NIBBLES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   logic [1:0]          r_state;
   logic [IW-1:0]       r_idx;
   logic                r_carry;
   logic [W-1:0]        r_a;
   logic [W-1:0]        r_b;
   logic [W-1:0]        r_sum;
   logic                r_cout;
`ifdef SERIAL_ADD_OVF_EN
   logic                r_ovf;
`endif

   logic [NIBBLE_W-1:0] w_na;
   logic [NIBBLE_W-1:0] w_nb;
   logic [NIBBLE_W-1:0] w_ns;
   logic                w_nc;
   logic                w_last;

   assign w_na   = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
   assign w_nb   = r_b[r_idx*NIBBLE_W +: NIBBLE_W];
   assign w_last = (r_idx == LAST_IDX);

   nibble_add4 u_add (
      .i_a    (w_na),
      .i_b    (w_nb),
      .i_cin  (r_carry),
      .o_sum  (w_ns),
      .o_cout (w_nc)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  // cin seeds the carry register so nibble 0 needs no special case
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_idx   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_sum[r_idx*NIBBLE_W +: NIBBLE_W] <= w_ns;
               r_carry <= w_nc;
               r_idx   <= r_idx + 1'b1;
               if (w_last) begin
                  r_cout  <= w_nc;
                  r_idx   <= '0;
                  r_state <= DONE;
`ifdef SERIAL_ADD_OVF_EN
                  // top nibble's MSB is sum[W-1]
                  r_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_ns[NIBBLE_W-1] != r_a[W-1]);
`endif
               end
            end
            DONE: begin
               if (out_ready) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
module tb_serial_add_seq;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         cin = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready;
   logic         out_valid;
   logic         cout;
   logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   serial_add_seq #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
`ifdef SERIAL_ADD_OVF_EN
      .ovf       (ovf),
`endif
      .cout      (cout)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         c;
      int           hold;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // reference: plain (W+1)-bit arithmetic
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
   endfunction

   task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic [W-1:0] es, input logic ec, input int hold, input string nm);
      int waitc;
      int lat;
      waitc = 0;
      while (!in_ready && waitc < 20) begin
         tick;
         waitc++;
      end
      chk({nm, " ready"}, 64'(in_ready), 64'd1);
      if (!in_ready) return;
      a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = 1'b0;
      tick;
      in_valid = 1'b0;
      // scramble operands: result must come from the latched copy
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      chk({nm, " busy"}, 64'(in_ready), 64'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick;
         lat++;
      end
      chk({nm, " latency"}, 64'(lat), 64'(NIBBLES));
      chk({nm, " sum"}, 64'(sum), 64'(es));
      chk({nm, " cout"}, 64'(cout), 64'(ec));
`ifdef SERIAL_ADD_OVF_EN
      chk({nm, " ovf"}, 64'(ovf), 64'((va[W-1] == vb[W-1]) && (es[W-1] != va[W-1])));
`endif
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1; a = 16'hAAAA; b = W'($urandom);
         tick;
         chk({nm, " hold valid"}, 64'(out_valid), 64'd1);
         chk({nm, " hold ready"}, 64'(in_ready), 64'd0);
         chk({nm, " hold sum"}, 64'(sum), 64'(es));
         chk({nm, " hold cout"}, 64'(cout), 64'(ec));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk({nm, " drop valid"}, 64'(out_valid), 64'd0);
      chk({nm, " idle ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1);
   end

   initial begin
      logic [W:0]   r;
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [W:0]   q[$];
      int           acc_cyc[$];
      int           cyc;
      int           waitc;

      tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0};
      tbl[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 0};
      tbl[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1};
      tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0};
      tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0};
      tbl[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 0};
      tbl[6] = '{16'h5A5A, 16'h0F0F, 1'b0, 16'h6969, 1'b0, 3};

      // reset state
      rst_n = 1'b0;
      tick; tick;
      rst_n = 1'b1;
      chk("rst in_ready", 64'(in_ready), 64'd1);
      chk("rst out_valid", 64'(out_valid), 64'd0);
      chk("rst sum", 64'(sum), 64'd0);
      chk("rst cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
      chk("rst ovf", 64'(ovf), 64'd0);
`endif
      tick;

      // directed table
      for (int i = 0; i < 7; i++)
         do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].c, tbl[i].hold,
               $sformatf("vec%0d", i));

      // reset two cycles into RUN abandons the operation
      a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tick; tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("midrst out_valid", 64'(out_valid), 64'd0);
      chk("midrst sum", 64'(sum), 64'd0);
      chk("midrst cout", 64'(cout), 64'd0);
      chk("midrst in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < NIBBLES + 2; i++) begin
         tick;
         chk("midrst no result", 64'(out_valid), 64'd0);
      end
      do_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 0, "postrst");

      // random operands against the model
      for (int i = 0; i < 20; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         r = model(ra, rb, rc);
         do_op(ra, rb, rc, r[W-1:0], r[W], int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
      end

      // back-to-back: in_valid and out_ready held high
      in_valid = 1'b1; out_ready = 1'b1;
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) begin
            if (q.size() == 0) chk("b2b unexpected result", 64'd1, 64'd0);
            else begin
               r = q.pop_front();
               chk("b2b sum", 64'(sum), 64'(r[W-1:0]));
               chk("b2b cout", 64'(cout), 64'(r[W]));
            end
         end
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, cin));
            acc_cyc.push_back(cyc);
         end
         tick;
         cyc++;
      end
      in_valid = 1'b0;
      waitc = 0;
      while (q.size() > 0 && waitc < 20) begin
         if (out_valid) begin
            r = q.pop_front();
            chk("drain sum", 64'(sum), 64'(r[W-1:0]));
            chk("drain cout", 64'(cout), 64'(r[W]));
         end
         tick;
         waitc++;
      end
      chk("drain empty", 64'(q.size()), 64'd0);
      out_ready = 1'b0;
      chk("b2b accept count", 64'(acc_cyc.size() >= 5), 64'd1);
      for (int i = 1; i < acc_cyc.size(); i++)
         chk("b2b spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(NIBBLES + 2));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
